// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared constants and types for the parking fee calculator.
//   NUM_SLOTS / BASE_FEE / RATE : default block parameters
//   FEE_W / TIME_W              : fee and time bus widths
//   exit_state_e                : exit FSM states
//   calc_fee()                  : BASE + RATE*duration, saturated to FEE_W
// ---------------------------------------------------------------------------
package parking_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int BASE_FEE  = 10;
  localparam int RATE      = 2;
  localparam int FEE_W     = 12;
  localparam int TIME_W    = 8;
  localparam int FEE_MAX   = (1 << FEE_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } exit_state_e;

  // Computed in 32-bit arithmetic so the saturation compare sees the true sum.
  function automatic logic [FEE_W-1:0] calc_fee(input logic [TIME_W-1:0] dur,
                                               input int base,
                                               input int rate);
    int full;
    full = base + rate * int'(dur);
    if (full > FEE_MAX) return FEE_W'(FEE_MAX);
    return FEE_W'(full);
  endfunction

endpackage

// File: rtl/slot_table.sv
// ---------------------------------------------------------------------------
// slot_table
// Per-slot entry-time registers and occupancy flags.
//   clk, reset            : clock, synchronous active-low reset
//   i_wr_en/slot/time     : entry write port (stores time, sets occupied)
//   i_clr_en/i_clr_slot   : exit clear port (clears occupied)
//   i_rd_slot / o_rd_time : combinational entry-time read port
//   o_occupied            : occupancy flags, one bit per slot
// ---------------------------------------------------------------------------
module slot_table
  import parking_pkg::*;
#(
  parameter  int SLOTS  = parking_pkg::NUM_SLOTS,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [SLOT_W-1:0] i_wr_slot,
  input  logic [TIME_W-1:0] i_wr_time,
  input  logic              i_clr_en,
  input  logic [SLOT_W-1:0] i_clr_slot,
  input  logic [SLOT_W-1:0] i_rd_slot,
  output logic [TIME_W-1:0] o_rd_time,
  output logic [SLOTS-1:0]  o_occupied
);

  logic [TIME_W-1:0] r_time [SLOTS];
  logic [SLOTS-1:0]  r_occupied;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the time table is small and its reset value is observable (a
      // stale time must never leak into a bill), so every entry is cleared.
      for (int i = 0; i < SLOTS; i++) r_time[i] <= '0;
      r_occupied <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the clear/write ordering below
      // independent of evaluation order; every reader sees pre-edge values.
      if (i_clr_en) r_occupied[i_clr_slot] <= 1'b0;
      if (i_wr_en) begin
        r_time[i_wr_slot]     <= i_wr_time;
        r_occupied[i_wr_slot] <= 1'b1;
      end
    end
  end

  assign o_rd_time  = r_time[i_rd_slot];
  assign o_occupied = r_occupied;

endmodule

// File: rtl/parking_fee_calc.sv
// ---------------------------------------------------------------------------
// parking_fee_calc
// Tracks car entries per slot and bills exits: duration = exit - entry time
// (8-bit wrap), fee = BASE_FEE + RATE*duration saturated at 4095.
//   clk, reset               : clock, synchronous active-low reset
//   time_value               : global time (wraps 255->0)
//   entry_valid/entry_slot   : entry request; entry_ack pulses on accept
//   exit_valid/exit_slot     : exit request, held until exit_ready
//   exit_ready               : exit FSM idle, request can be taken
//   fee_valid/duration/fee   : bill result, pulse 2 cycles after handshake
//   occupied                 : per-slot occupancy flags
//   error                    : pulse for a rejected entry or exit
// ---------------------------------------------------------------------------
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter  int NUM_SLOTS = parking_pkg::NUM_SLOTS,
  parameter  int BASE_FEE  = parking_pkg::BASE_FEE,
  parameter  int RATE      = parking_pkg::RATE,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TIME_W-1:0]    time_value,
  input  logic                 entry_valid,
  input  logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_valid,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 exit_ready,
  output logic                 entry_ack,
  output logic                 fee_valid,
  output logic [TIME_W-1:0]    duration,
  output logic [FEE_W-1:0]     fee,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 error
);

  exit_state_e       r_state;
  logic [TIME_W-1:0] r_exit_time;
  logic [TIME_W-1:0] r_entry_time;
  logic [TIME_W-1:0] r_duration;
  logic [FEE_W-1:0]  r_fee;
  logic              r_entry_ack;
  logic              r_fee_valid;
  logic              r_error;

  logic [NUM_SLOTS-1:0] w_occupied;
  logic [TIME_W-1:0]    w_rd_time;
  logic                 w_exit_hit;
  logic                 w_exit_accept;
  logic                 w_exit_reject;
  logic                 w_entry_accept;
  logic [TIME_W-1:0]    w_duration;
  logic [FEE_W-1:0]     w_fee;

  assign w_exit_hit    = exit_valid && (r_state == S_IDLE);
  assign w_exit_accept = w_exit_hit &&  w_occupied[exit_slot];
  assign w_exit_reject = w_exit_hit && !w_occupied[exit_slot];

  // A same-slot exit can only be accepted if the slot is occupied, and an
  // occupied slot already refuses entry, so the exit wins without extra logic.
  assign w_entry_accept = entry_valid && !w_occupied[entry_slot];

  assign w_duration = r_exit_time - r_entry_time;
  assign w_fee      = calc_fee(w_duration, BASE_FEE, RATE);

  slot_table #(.SLOTS(NUM_SLOTS)) u_slot_table (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_entry_accept),
    .i_wr_slot  (entry_slot),
    .i_wr_time  (time_value),
    .i_clr_en   (w_exit_accept),
    .i_clr_slot (exit_slot),
    .i_rd_slot  (exit_slot),
    .o_rd_time  (w_rd_time),
    .o_occupied (w_occupied)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_exit_time  <= '0;
      r_entry_time <= '0;
      r_duration   <= '0;
      r_fee        <= '0;
      r_entry_ack  <= 1'b0;
      r_fee_valid  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_entry_ack <= w_entry_accept;
      r_error     <= (entry_valid && !w_entry_accept) || w_exit_reject;
      r_fee_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_exit_accept) begin
            // Entry time is captured at the handshake so a re-entry to this
            // slot while billing cannot disturb the bill.
            r_exit_time  <= time_value;
            r_entry_time <= w_rd_time;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_duration  <= w_duration;
          r_fee       <= w_fee;
          r_fee_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exit_ready = (r_state == S_IDLE);
  assign entry_ack  = r_entry_ack;
  assign fee_valid  = r_fee_valid;
  assign duration   = r_duration;
  assign fee        = r_fee;
  assign occupied   = w_occupied;
  assign error      = r_error;

endmodule

// File: tb/tb_parking_fee_calc.sv
// ---------------------------------------------------------------------------
// tb_parking_fee_calc
// Directed scenarios for parking_fee_calc with hand-computed expectations.
// A second instance with RATE=20 shares the stimulus to reach fee saturation.
// ---------------------------------------------------------------------------
module tb_parking_fee_calc;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] time_value;
  logic       entry_valid;
  logic [1:0] entry_slot;
  logic       exit_valid;
  logic [1:0] exit_slot;

  logic        exit_ready, entry_ack, fee_valid, error;
  logic [7:0]  duration;
  logic [11:0] fee;
  logic [3:0]  occupied;

  logic        s_exit_ready, s_entry_ack, s_fee_valid, s_error;
  logic [7:0]  s_duration;
  logic [11:0] s_fee;
  logic [3:0]  s_occupied;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parking_fee_calc dut (
    .clk(clk), .reset(reset), .time_value(time_value),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .exit_ready(exit_ready), .entry_ack(entry_ack), .fee_valid(fee_valid),
    .duration(duration), .fee(fee), .occupied(occupied), .error(error)
  );

  parking_fee_calc #(.RATE(20)) dut_sat (
    .clk(clk), .reset(reset), .time_value(time_value),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_valid(exit_valid), .exit_slot(exit_slot),
    .exit_ready(s_exit_ready), .entry_ack(s_entry_ack), .fee_valid(s_fee_valid),
    .duration(s_duration), .fee(s_fee), .occupied(s_occupied), .error(s_error)
  );

  // Advance one edge; outputs are then sampled and inputs changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [1:0] slot, input logic [7:0] t);
    time_value  = t;
    entry_slot  = slot;
    entry_valid = 1'b1;
    tick();
    entry_valid = 1'b0;
  endtask

  task automatic exit_handshake(input logic [1:0] slot, input logic [7:0] t);
    time_value = t;
    exit_slot  = slot;
    exit_valid = 1'b1;
    tick();
    exit_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; time_value = '0; entry_valid = 1'b0; entry_slot = '0;
    exit_valid = 1'b0; exit_slot = '0;
    tick(); tick();
    n_cmp++; if (occupied !== 4'b0000) begin n_bad++; $display("FAIL rst_occupied: got %b want 0000", occupied); end
    n_cmp++; if (fee !== 12'd0) begin n_bad++; $display("FAIL rst_fee: got %0d want 0", fee); end
    n_cmp++; if (duration !== 8'd0) begin n_bad++; $display("FAIL rst_duration: got %0d want 0", duration); end
    n_cmp++; if ({fee_valid, entry_ack, error} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {fee_valid, entry_ack, error}); end
    reset = 1'b1;
    tick();
    n_cmp++; if (exit_ready !== 1'b1) begin n_bad++; $display("FAIL rst_exit_ready: got %b want 1", exit_ready); end
  endtask

  task automatic test_basic_exit();
    drive_entry(2'd1, 8'd5);
    n_cmp++; if (entry_ack !== 1'b1) begin n_bad++; $display("FAIL basic_entry_ack: got %b want 1", entry_ack); end
    n_cmp++; if (occupied !== 4'b0010) begin n_bad++; $display("FAIL basic_occupied: got %b want 0010", occupied); end
    tick();
    n_cmp++; if (entry_ack !== 1'b0) begin n_bad++; $display("FAIL basic_ack_pulse: got %b want 0", entry_ack); end
    exit_handshake(2'd1, 8'd25);
    n_cmp++; if ({exit_ready, fee_valid, occupied[1]} !== 3'b000) begin n_bad++; $display("FAIL basic_calc_cycle: got %b want 000", {exit_ready, fee_valid, occupied[1]}); end
    tick();
    n_cmp++; if (fee_valid !== 1'b1) begin n_bad++; $display("FAIL basic_fee_valid: got %b want 1", fee_valid); end
    n_cmp++; if (duration !== 8'd20) begin n_bad++; $display("FAIL basic_duration: got %0d want 20", duration); end
    n_cmp++; if (fee !== 12'd50) begin n_bad++; $display("FAIL basic_fee: got %0d want 50", fee); end
    tick();
    n_cmp++; if ({fee_valid, exit_ready} !== 2'b01) begin n_bad++; $display("FAIL basic_done: got %b want 01", {fee_valid, exit_ready}); end
    n_cmp++; if (fee !== 12'd50) begin n_bad++; $display("FAIL basic_fee_hold: got %0d want 50", fee); end
  endtask

  task automatic test_wrap();
    drive_entry(2'd0, 8'd250);
    exit_handshake(2'd0, 8'd4);
    tick();
    n_cmp++; if ({fee_valid, duration} !== {1'b1, 8'd10}) begin n_bad++; $display("FAIL wrap_duration: got v=%b d=%0d want v=1 d=10", fee_valid, duration); end
    n_cmp++; if (fee !== 12'd30) begin n_bad++; $display("FAIL wrap_fee: got %0d want 30", fee); end
    tick();
  endtask

  task automatic test_double_entry();
    drive_entry(2'd2, 8'd7);
    drive_entry(2'd2, 8'd9);
    n_cmp++; if ({entry_ack, error} !== 2'b01) begin n_bad++; $display("FAIL dbl_reject: got ack/err %b want 01", {entry_ack, error}); end
    tick();
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL dbl_err_pulse: got %b want 0", error); end
    exit_handshake(2'd2, 8'd17);
    tick();
    n_cmp++; if (duration !== 8'd10) begin n_bad++; $display("FAIL dbl_time_kept: got %0d want 10", duration); end
    tick();
  endtask

  task automatic test_exit_free();
    exit_handshake(2'd3, 8'd30);
    n_cmp++; if ({error, exit_ready, fee_valid} !== 3'b110) begin n_bad++; $display("FAIL free_exit: got err/rdy/fv %b want 110", {error, exit_ready, fee_valid}); end
    tick();
    n_cmp++; if ({error, fee_valid} !== 2'b00) begin n_bad++; $display("FAIL free_exit_p1: got %b want 00", {error, fee_valid}); end
    tick();
    n_cmp++; if ({fee_valid, exit_ready} !== 2'b01) begin n_bad++; $display("FAIL free_exit_p2: got %b want 01", {fee_valid, exit_ready}); end
  endtask

  task automatic test_same_slot();
    drive_entry(2'd0, 8'd100);
    time_value = 8'd110; exit_slot = 2'd0; exit_valid = 1'b1;
    entry_slot = 2'd0; entry_valid = 1'b1;
    tick();
    exit_valid = 1'b0; entry_valid = 1'b0;
    n_cmp++; if ({entry_ack, error} !== 2'b01) begin n_bad++; $display("FAIL same_reject: got ack/err %b want 01", {entry_ack, error}); end
    n_cmp++; if (occupied[0] !== 1'b0) begin n_bad++; $display("FAIL same_occupied: got %b want 0", occupied[0]); end
    tick();
    n_cmp++; if ({fee_valid, fee} !== {1'b1, 12'd30}) begin n_bad++; $display("FAIL same_fee: got v=%b fee=%0d want v=1 fee=30", fee_valid, fee); end
    tick();
  endtask

  task automatic test_diff_slots();
    drive_entry(2'd3, 8'd40);
    time_value = 8'd60; exit_slot = 2'd3; exit_valid = 1'b1;
    entry_slot = 2'd1; entry_valid = 1'b1;
    tick();
    exit_valid = 1'b0; entry_valid = 1'b0;
    n_cmp++; if ({entry_ack, error, occupied} !== {2'b10, 4'b0010}) begin n_bad++; $display("FAIL diff_entry: got ack/err/occ %b want 100010", {entry_ack, error, occupied}); end
    tick();
    n_cmp++; if ({fee_valid, duration, fee} !== {1'b1, 8'd20, 12'd50}) begin n_bad++; $display("FAIL diff_fee: got v=%b d=%0d f=%0d want 1/20/50", fee_valid, duration, fee); end
    tick();
  endtask

  task automatic test_reentry_calc();
    exit_handshake(2'd1, 8'd63);
    entry_slot = 2'd1; entry_valid = 1'b1;
    tick();
    entry_valid = 1'b0;
    n_cmp++; if ({entry_ack, occupied} !== {1'b1, 4'b0010}) begin n_bad++; $display("FAIL reentry_ack: got ack/occ %b want 10010", {entry_ack, occupied}); end
    n_cmp++; if ({fee_valid, duration, fee} !== {1'b1, 8'd3, 12'd16}) begin n_bad++; $display("FAIL reentry_fee: got v=%b d=%0d f=%0d want 1/3/16", fee_valid, duration, fee); end
    tick();
    exit_handshake(2'd1, 8'd63);
    tick();
    n_cmp++; if ({fee_valid, duration, fee} !== {1'b1, 8'd0, 12'd10}) begin n_bad++; $display("FAIL zero_dur: got v=%b d=%0d f=%0d want 1/0/10", fee_valid, duration, fee); end
    tick();
  endtask

  task automatic test_saturation();
    drive_entry(2'd2, 8'd0);
    n_cmp++; if ({s_entry_ack, s_error, s_occupied} !== {2'b10, 4'b0100}) begin n_bad++; $display("FAIL sat_entry: got %b want 100100", {s_entry_ack, s_error, s_occupied}); end
    exit_handshake(2'd2, 8'd255);
    n_cmp++; if (s_exit_ready !== 1'b0) begin n_bad++; $display("FAIL sat_busy: got %b want 0", s_exit_ready); end
    tick();
    n_cmp++; if ({duration, fee} !== {8'd255, 12'd520}) begin n_bad++; $display("FAIL max_dur_fee: got d=%0d f=%0d want 255/520", duration, fee); end
    n_cmp++; if ({s_fee_valid, s_duration, s_fee} !== {1'b1, 8'd255, 12'd4095}) begin n_bad++; $display("FAIL sat_fee: got v=%b d=%0d f=%0d want 1/255/4095", s_fee_valid, s_duration, s_fee); end
    tick();
  endtask

  task automatic test_reset_calc();
    drive_entry(2'd0, 8'd1);
    exit_handshake(2'd0, 8'd5);
    reset = 1'b0;
    tick();
    n_cmp++; if ({fee_valid, entry_ack, error, occupied} !== 7'b0) begin n_bad++; $display("FAIL rcalc_flags: got %b want 0000000", {fee_valid, entry_ack, error, occupied}); end
    n_cmp++; if ({duration, fee} !== 20'd0) begin n_bad++; $display("FAIL rcalc_result: got d=%0d f=%0d want 0/0", duration, fee); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({fee_valid, exit_ready} !== 2'b01) begin n_bad++; $display("FAIL rcalc_release: got %b want 01", {fee_valid, exit_ready}); end
    tick();
    n_cmp++; if (fee_valid !== 1'b0) begin n_bad++; $display("FAIL rcalc_no_bill: got %b want 0", fee_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_exit();
    test_wrap();
    test_double_entry();
    test_exit_free();
    test_same_slot();
    test_diff_slots();
    test_reentry_calc();
    test_saturation();
    test_reset_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
